// File: rtl/redirect_ctrl.sv
// Front-end redirect sequencer: turns resolved EXU control flow (and the boot
// fetch) into a redirect request to IFU plus a timed IF/ID flush.
module redirect_ctrl #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned     DRAIN_CYC = 2,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             exu_valid_i,
  output logic             exu_ready_o,
  input  logic [PC_W-1:0]  exu_npc_i,
  input  logic [PC_W-1:0]  exu_pred_npc_i,
  input  logic             exu_is_trap_i,
  output logic             redirect_valid_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic             flush_o,
  output logic [CNT_W-1:0] mispred_cnt_o,
  output logic [CNT_W-1:0] trap_cnt_o
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_REDIR = 2'd1,
    ST_DRAIN = 2'd2,
    ST_IDLE  = 2'd3
  } state_e;

  // The REDIR->DRAIN edge already counts as one drain cycle, hence the -1.
  localparam logic [3:0]       DRAIN_INIT = (DRAIN_CYC == 32'd0) ? 4'd0 : 4'(DRAIN_CYC - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e            state_r;
  logic              exu_ready_r;
  logic              redirect_valid_r;
  logic [PC_W-1:0]   redirect_pc_r;
  logic              flush_r;
  logic [3:0]        drain_cnt_r;
  logic [CNT_W-1:0]  mispred_cnt_r;
  logic [CNT_W-1:0]  trap_cnt_r;

  logic accept_s;
  logic need_redir_s;
  logic handshake_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == CNT_MAX) ? val : val + CNT_W'(1);
  endfunction

  assign accept_s     = exu_valid_i & exu_ready_r;
  assign need_redir_s = exu_is_trap_i | (exu_npc_i != exu_pred_npc_i);
  assign handshake_s  = redirect_valid_r & redirect_ready_i;

  // Redirect sequencing FSM with all outputs and counters registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r          <= ST_INIT;
      exu_ready_r      <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= {PC_W{1'b0}};
      flush_r          <= 1'b0;
      drain_cnt_r      <= 4'd0;
      mispred_cnt_r    <= {CNT_W{1'b0}};
      trap_cnt_r       <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          state_r          <= ST_REDIR;
          redirect_valid_r <= 1'b1;
          redirect_pc_r    <= RESET_PC;
          flush_r          <= 1'b1;
          exu_ready_r      <= 1'b0;
        end
        ST_REDIR: begin
          if (handshake_s) begin
            redirect_valid_r <= 1'b0;
            if (DRAIN_CYC == 32'd0) begin
              state_r     <= ST_IDLE;
              flush_r     <= 1'b0;
              exu_ready_r <= 1'b1;
            end else begin
              state_r     <= ST_DRAIN;
              drain_cnt_r <= DRAIN_INIT;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == 4'd0) begin
            state_r     <= ST_IDLE;
            flush_r     <= 1'b0;
            exu_ready_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - 4'd1;
          end
        end
        ST_IDLE: begin
          if (accept_s && need_redir_s) begin
            state_r          <= ST_REDIR;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= exu_npc_i;
            flush_r          <= 1'b1;
            exu_ready_r      <= 1'b0;
            // A trap is always attributed to the trap counter, even on a PC match.
            if (exu_is_trap_i) begin
              trap_cnt_r <= sat_inc(trap_cnt_r);
            end else begin
              mispred_cnt_r <= sat_inc(mispred_cnt_r);
            end
          end
        end
        default: begin
          state_r          <= ST_INIT;
          exu_ready_r      <= 1'b0;
          redirect_valid_r <= 1'b0;
          flush_r          <= 1'b0;
          drain_cnt_r      <= 4'd0;
        end
      endcase
    end
  end

  assign exu_ready_o      = exu_ready_r;
  assign redirect_valid_o = redirect_valid_r;
  assign redirect_pc_o    = redirect_pc_r;
  assign flush_o          = flush_r;
  assign mispred_cnt_o    = mispred_cnt_r;
  assign trap_cnt_o       = trap_cnt_r;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: two configurations share one stimulus stream and are
// each checked every cycle against a timeline-based reference model.
module tb_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        exu_valid;
  logic [31:0] exu_npc;
  logic [31:0] exu_pred;
  logic        exu_trap;
  logic        rdy_in;

  logic        a_ready, a_valid, a_flush;
  logic [31:0] a_pc;
  logic [15:0] a_mis, a_trp;
  logic        b_ready, b_valid, b_flush;
  logic [31:0] b_pc;
  logic [3:0]  b_mis, b_trp;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [31:0] BOOT_PC = 32'h8000_0000;
  localparam int DRAIN[2] = '{2, 0};
  localparam int CMAX[2]  = '{65535, 15};

  redirect_ctrl #(.PC_W(32), .RESET_PC(BOOT_PC), .DRAIN_CYC(2), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .exu_valid_i(exu_valid), .exu_ready_o(a_ready),
    .exu_npc_i(exu_npc), .exu_pred_npc_i(exu_pred), .exu_is_trap_i(exu_trap),
    .redirect_valid_o(a_valid), .redirect_pc_o(a_pc), .redirect_ready_i(rdy_in),
    .flush_o(a_flush), .mispred_cnt_o(a_mis), .trap_cnt_o(a_trp));

  redirect_ctrl #(.PC_W(32), .RESET_PC(BOOT_PC), .DRAIN_CYC(0), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .exu_valid_i(exu_valid), .exu_ready_o(b_ready),
    .exu_npc_i(exu_npc), .exu_pred_npc_i(exu_pred), .exu_is_trap_i(exu_trap),
    .redirect_valid_o(b_valid), .redirect_pc_o(b_pc), .redirect_ready_i(rdy_in),
    .flush_o(b_flush), .mispred_cnt_o(b_mis), .trap_cnt_o(b_trp));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: boot pending flag plus absolute cycle at which draining ends.
  bit          m_boot[2];
  bit          m_valid[2], m_flush[2], m_ready[2];
  logic [31:0] m_pc[2];
  int          m_mis[2], m_trp[2], m_idle_at[2];
  int          cyc;

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      m_boot[i] = 1'b1; m_valid[i] = 1'b0; m_flush[i] = 1'b0; m_ready[i] = 1'b0;
      m_pc[i] = 32'd0; m_mis[i] = 0; m_trp[i] = 0; m_idle_at[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    if (m_boot[i]) begin
      m_boot[i] = 1'b0; m_valid[i] = 1'b1; m_pc[i] = BOOT_PC; m_flush[i] = 1'b1;
    end else if (m_valid[i]) begin
      if (rdy_in) begin
        m_valid[i]   = 1'b0;
        m_idle_at[i] = cyc + DRAIN[i];
        if (DRAIN[i] == 0) begin
          m_flush[i] = 1'b0; m_ready[i] = 1'b1;
        end
      end
    end else if (m_flush[i]) begin
      if (cyc == m_idle_at[i]) begin
        m_flush[i] = 1'b0; m_ready[i] = 1'b1;
      end
    end else if (m_ready[i] && exu_valid && (exu_trap || exu_npc != exu_pred)) begin
      m_valid[i] = 1'b1; m_pc[i] = exu_npc; m_flush[i] = 1'b1; m_ready[i] = 1'b0;
      if (exu_trap) m_trp[i] = (m_trp[i] >= CMAX[i]) ? CMAX[i] : m_trp[i] + 1;
      else          m_mis[i] = (m_mis[i] >= CMAX[i]) ? CMAX[i] : m_mis[i] + 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc = cyc + 1;
      model_step(0);
      model_step(1);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("a.ready", 32'(a_ready), 32'(m_ready[0]));
    check_eq("a.valid", 32'(a_valid), 32'(m_valid[0]));
    check_eq("a.pc",    a_pc,         m_pc[0]);
    check_eq("a.flush", 32'(a_flush), 32'(m_flush[0]));
    check_eq("a.mis",   32'(a_mis),   32'(m_mis[0]));
    check_eq("a.trap",  32'(a_trp),   32'(m_trp[0]));
    check_eq("b.ready", 32'(b_ready), 32'(m_ready[1]));
    check_eq("b.valid", 32'(b_valid), 32'(m_valid[1]));
    check_eq("b.pc",    b_pc,         m_pc[1]);
    check_eq("b.flush", 32'(b_flush), 32'(m_flush[1]));
    check_eq("b.mis",   32'(b_mis),   32'(m_mis[1]));
    check_eq("b.trap",  32'(b_trp),   32'(m_trp[1]));
  endtask

  // Every cycle, away from the active edge, both DUTs are compared to the model.
  always @(negedge clk) compare_all();

  initial begin
    rst_n = 1'b0; exu_valid = 1'b0; exu_npc = 32'd0; exu_pred = 32'd0;
    exu_trap = 1'b0; rdy_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Boot redirect, then DRAIN_CYC=2 drain on dut_a.
    @(negedge clk);
    check_eq("boot.valid", 32'(a_valid), 32'd1);
    check_eq("boot.pc",    a_pc,         BOOT_PC);
    check_eq("boot.flush", 32'(a_flush), 32'd1);
    check_eq("boot.cnt",   32'(a_mis) + 32'(a_trp), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("boot.ready", 32'(a_ready), 32'd1);

    // Matching accepts back-to-back.
    exu_valid = 1'b1; exu_npc = 32'h8000_0010; exu_pred = 32'h8000_0010; exu_trap = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("match.ready", 32'(a_ready), 32'd1);
    end
    exu_valid = 1'b0;
    check_eq("match.cnt", 32'(a_mis), 32'd0);

    // Mispredict with IFU stalling the redirect.
    rdy_in = 1'b0; exu_valid = 1'b1; exu_npc = 32'h8000_0100; exu_pred = 32'h8000_0008;
    @(negedge clk);
    exu_valid = 1'b0;
    check_eq("misp.valid", 32'(a_valid), 32'd1);
    check_eq("misp.pc",    a_pc,         32'h8000_0100);
    check_eq("misp.cnt",   32'(a_mis),   32'd1);
    repeat (3) begin
      @(negedge clk);
      check_eq("misp.hold", a_pc, 32'h8000_0100);
    end
    rdy_in = 1'b1;
    repeat (5) @(negedge clk);

    // Trap with matching PCs still redirects and counts as a trap.
    exu_valid = 1'b1; exu_trap = 1'b1; exu_npc = 32'h8000_0200; exu_pred = 32'h8000_0200;
    @(negedge clk);
    exu_valid = 1'b0; exu_trap = 1'b0;
    check_eq("trap.pc",  a_pc,         32'h8000_0200);
    check_eq("trap.cnt", 32'(a_trp),   32'd1);
    check_eq("trap.mis", 32'(a_mis),   32'd1);
    repeat (5) @(negedge clk);

    // Sustained mispredicts saturate the 4-bit counter.
    exu_valid = 1'b1; exu_npc = 32'h8000_1000; exu_pred = 32'h8000_2000;
    repeat (80) @(negedge clk);
    exu_valid = 1'b0;
    check_eq("sat.b", 32'(b_mis), 32'hF);
    repeat (6) @(negedge clk);

    // Reset while both DUTs wait in REDIR.
    rdy_in = 1'b0; exu_valid = 1'b1; exu_npc = 32'h8000_3000; exu_pred = 32'h8000_3004;
    @(negedge clk);
    exu_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort.a_valid", 32'(a_valid), 32'd0);
    check_eq("abort.b_flush", 32'(b_flush), 32'd0);
    check_eq("abort.b_mis",   32'(b_mis),   32'd0);
    @(negedge clk);
    rdy_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reboot.pc", b_pc, BOOT_PC);
    @(negedge clk);
    check_eq("reboot.ready", 32'(b_ready), 32'd1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      exu_valid = 1'($urandom_range(0, 1));
      exu_pred  = $urandom;
      exu_npc   = ($urandom_range(0, 1) == 0) ? exu_pred : $urandom;
      exu_trap  = ($urandom_range(0, 7) == 0);
      rdy_in    = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
